if_fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline. Owns the PC, issues requests to the

---
 rtl/rv32i_types.sv | 16 +
 rtl/if_id_reg.sv | 34 +++
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: NOP encoding, fetch FSM states and a saturating counter helper.
package rv32i_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {pc, instr, valid}; a flush beats a simultaneous load.
module if_id_reg
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic [WIDTH-1:0] next_pc,
  input  logic [WIDTH-1:0] next_instr,
  input  logic             next_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      instr <= WIDTH'(NOP_INSTR);
      valid <= 1'b0;
    end else if (flush) begin
      instr <= WIDTH'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= next_pc;
      instr <= next_instr;
      valid <= next_valid;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I IF stage: PC, imem request FSM and IF/ID register.
// Optional perf counters (bubbles, dropped responses) are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_stage
  import rv32i_types::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0060)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] imem_address_o,
  output logic             imem_read_o,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             imem_resp_i,
  input  logic             IF_HD_PC_write_i,
  input  logic             IF_ID_HD_write_i,
  input  logic             EX_br_en_i,
  input  logic [WIDTH-1:0] EX_br_target_i,
  output logic [WIDTH-1:0] ID_pc_o,
  output logic [WIDTH-1:0] ID_instr_o,
  output logic             ID_valid_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_bubble_o,
  output logic [31:0]      perf_discard_o
`endif
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc, pc_next, hold_q, hold_next, redir_q, redir_next;
  logic             id_load, id_flush, id_valid_in;
  logic [WIDTH-1:0] id_instr_in;

  assign imem_address_o = {pc[WIDTH-1:2], 2'b00};
  assign imem_read_o    = rst && (state != HOLD);

  // Redirect always outranks the hazard stall; the old fetch address is kept until its response arrives.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    hold_next   = hold_q;
    redir_next  = redir_q;
    id_load     = 1'b0;
    id_flush    = 1'b0;
    id_valid_in = 1'b1;
    id_instr_in = imem_rdata_i;
    case (state)
      FETCH: begin
        if (imem_resp_i) begin
          if (EX_br_en_i) begin
            id_flush = 1'b1;
            pc_next  = EX_br_target_i;
          end else if (IF_ID_HD_write_i) begin
            id_load = 1'b1;
            if (IF_HD_PC_write_i) pc_next = pc + WIDTH'(4);
          end else begin
            hold_next  = imem_rdata_i;
            state_next = HOLD;
          end
        end else if (EX_br_en_i) begin
          id_flush   = 1'b1;
          redir_next = EX_br_target_i;
          state_next = DISCARD;
        end else if (IF_ID_HD_write_i) begin
          id_load     = 1'b1;
          id_valid_in = 1'b0;
          id_instr_in = WIDTH'(NOP_INSTR);
        end
      end
      HOLD: begin
        if (EX_br_en_i) begin
          id_flush   = 1'b1;
          pc_next    = EX_br_target_i;
          state_next = FETCH;
        end else if (IF_ID_HD_write_i) begin
          id_load     = 1'b1;
          id_instr_in = hold_q;
          pc_next     = pc + WIDTH'(4);
          state_next  = FETCH;
        end
      end
      DISCARD: begin
        if (EX_br_en_i) begin
          id_flush   = 1'b1;
          redir_next = EX_br_target_i;
        end
        if (imem_resp_i) begin
          pc_next    = EX_br_en_i ? EX_br_target_i : redir_q;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      hold_q  <= '0;
      redir_q <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      hold_q  <= hold_next;
      redir_q <= redir_next;
    end
  end

  if_id_reg #(.WIDTH(WIDTH)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (id_load),
    .flush      (id_flush),
    .next_pc    (pc),
    .next_instr (id_instr_in),
    .next_valid (id_valid_in),
    .pc         (ID_pc_o),
    .instr      (ID_instr_o),
    .valid      (ID_valid_o)
  );

`ifdef IF_FETCH_PERF_EN
  logic bubble_evt, discard_evt;

  assign bubble_evt  = (state == FETCH) && !imem_resp_i && !EX_br_en_i && IF_ID_HD_write_i;
  assign discard_evt = ((state == FETCH) && imem_resp_i && EX_br_en_i) ||
                       ((state == DISCARD) && imem_resp_i) ||
                       ((state == HOLD) && EX_br_en_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubble_o  <= '0;
      perf_discard_o <= '0;
    end else begin
      if (bubble_evt)  perf_bubble_o  <= sat_inc(perf_bubble_o);
      if (discard_evt) perf_discard_o <= sat_inc(perf_discard_o);
    end
  end
`endif

endmodule
